// File: rtl/ticket_pkg.sv
// Shared types and constants for the ticket vending controller.
// Holds the controller state encoding and the coin denomination lookup.
package ticket_pkg;

  localparam int MONEY_W         = 8;
  localparam int CHANGE_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAY      = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  // Yuan value of each coin slot code.
  function automatic logic [4:0] coin_value(input logic [1:0] sel);
    logic [4:0] v;
    case (sel)
      2'd0:    v = 5'd1;
      2'd1:    v = 5'd5;
      2'd2:    v = 5'd10;
      default: v = 5'd20;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_accum.sv
// Saturating inserted-money accumulator with coin refusal.
// A coin is taken only while enabled and only if the new total stays within MAX_MONEY.
module coin_accum
  import ticket_pkg::*;
#(
  parameter int MAX_MONEY = 99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               coin_valid,
  input  logic [1:0]         coin_sel,
  output logic [MONEY_W-1:0] money,
  output logic               coin_reject,
  output logic [MONEY_W-1:0] money_nxt
);

  localparam logic [MONEY_W:0] MAX_W = (MONEY_W + 1)'(MAX_MONEY);

  logic [MONEY_W:0] w_sum;
  logic             w_accept;

  // One spare bit keeps the sum from wrapping before the ceiling compare.
  assign w_sum     = {1'b0, money} + {{(MONEY_W - 4){1'b0}}, coin_value(coin_sel)};
  assign w_accept  = en && coin_valid && (w_sum <= MAX_W);
  assign money_nxt = w_accept ? w_sum[MONEY_W-1:0] : money;

  always_ff @(posedge clk) begin
    if (rst) begin
      money       <= '0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= coin_valid && !w_accept;
      if (clr)
        money <= '0;
      else if (w_accept)
        money <= w_sum[MONEY_W-1:0];
    end
  end

endmodule

// File: rtl/ticket_vend_ctrl.sv
// Ticket vending sequencer: selection latch, payment, dispense pulses, change hold.
// Optional PAY inactivity timeout is built when TICKET_TIMEOUT_EN is defined.
//
// state    | meaning
// IDLE     | waiting for a valid selection; coins are refused
// PAY      | accumulating coins until money covers price, or cancel/timeout
// DISPENSE | one ticket_pulse per ticket from a down-counter
// CHANGE   | money_return presented with change_valid for CHANGE_HOLD cycles
module ticket_vend_ctrl
  import ticket_pkg::*;
#(
  parameter int MAX_MONEY   = 99,
  parameter int CHANGE_HOLD = CHANGE_HOLD_DEF
`ifdef TICKET_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_valid,
  input  logic [1:0]         sel_type,
  input  logic [1:0]         sel_count,
  input  logic               coin_valid,
  input  logic [1:0]         coin_sel,
  input  logic               cancel,
  output logic [MONEY_W-1:0] money,
  output logic [1:0]         ticket_type,
  output logic [1:0]         ticket_count,
  output logic [MONEY_W-1:0] money_return,
  output logic               ticket_pulse,
  output logic               coin_reject,
  output logic               change_valid,
  output logic               busy
`ifdef TICKET_TIMEOUT_EN
  ,
  output logic               timeout_flag
`endif
);

  state_t             r_state;
  logic [1:0]         r_dcnt;
  logic [7:0]         r_hold;
  logic [3:0]         w_price;
  logic               w_sel_ok;
  logic               w_paid;
  logic               w_clr;
  logic               w_tmo;
  logic               w_abort;
  logic [MONEY_W-1:0] w_money_nxt;

  assign w_price  = {2'b00, ticket_type} * {2'b00, ticket_count};
  assign w_sel_ok = sel_valid && (sel_type != 2'd0) && (sel_count != 2'd0);
  assign w_paid   = money >= {{(MONEY_W - 4){1'b0}}, w_price};
  assign w_clr    = ((r_state == IDLE) && w_sel_ok) ||
                    ((r_state == CHANGE) && (r_hold == 8'd0));
  assign w_abort  = cancel || w_tmo;

  coin_accum #(
    .MAX_MONEY (MAX_MONEY)
  ) u_coin_accum (
    .clk         (clk),
    .rst         (rst),
    .clr         (w_clr),
    .en          (r_state == PAY),
    .coin_valid  (coin_valid),
    .coin_sel    (coin_sel),
    .money       (money),
    .coin_reject (coin_reject),
    .money_nxt   (w_money_nxt)
  );

`ifdef TICKET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] r_to_cnt;

  assign w_tmo = (r_state == PAY) && !coin_valid && (r_to_cnt == '0);

  // Reloads outside PAY and on every coin, so expiry means TIMEOUT_CYC idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      timeout_flag <= w_tmo;
      if ((r_state != PAY) || coin_valid)
        r_to_cnt <= TO_W'(TIMEOUT_CYC - 1);
      else if (r_to_cnt != '0)
        r_to_cnt <= r_to_cnt - TO_W'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_dcnt       <= 2'd0;
      r_hold       <= 8'd0;
      ticket_type  <= 2'd0;
      ticket_count <= 2'd0;
      money_return <= '0;
      ticket_pulse <= 1'b0;
      change_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      ticket_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_sel_ok) begin
            ticket_type  <= sel_type;
            ticket_count <= sel_count;
            busy         <= 1'b1;
            r_state      <= PAY;
          end
        end
        PAY: begin
          // Refund uses the post-coin total so a same-cycle coin is returned too.
          if (w_abort) begin
            money_return <= w_money_nxt;
            change_valid <= 1'b1;
            r_hold       <= 8'(CHANGE_HOLD - 1);
            r_state      <= CHANGE;
          end else if (w_paid) begin
            ticket_pulse <= 1'b1;
            r_dcnt       <= ticket_count - 2'd1;
            r_state      <= DISPENSE;
          end
        end
        DISPENSE: begin
          if (r_dcnt == 2'd0) begin
            money_return <= money - {{(MONEY_W - 4){1'b0}}, w_price};
            change_valid <= 1'b1;
            r_hold       <= 8'(CHANGE_HOLD - 1);
            r_state      <= CHANGE;
          end else begin
            ticket_pulse <= 1'b1;
            r_dcnt       <= r_dcnt - 2'd1;
          end
        end
        CHANGE: begin
          if (r_hold == 8'd0) begin
            change_valid <= 1'b0;
            money_return <= '0;
            ticket_type  <= 2'd0;
            ticket_count <= 2'd0;
            busy         <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
